// File: rtl/subword_mem_ctrl.sv
// subword_mem_ctrl: load/store sequencer between the MEM stage and a
// word-wide single-port synchronous memory without byte enables.
//   Loads : one word read, big-endian lane extract, sign/zero extension.
//   Stores: byte/half stores do read-modify-write; word stores write directly.
// Ports:
//   clk, rst                      clock, async active-high reset
//   req_valid/req_ready           request handshake (accept on valid & ready)
//   req_we/size/signed/addr/wdata request fields
//   rsp_valid/rsp_rdata/rsp_err   one-cycle completion pulse + result
//   mem_req/we/addr/wdata/rdata   memory port (rdata valid 1 cycle after read)
// Build option: define LSU_ALIGN_TRAP_EN to complete misaligned accesses with
// rsp_err=1 and no memory access; otherwise low address bits are forced to
// alignment and rsp_err stays 0.

// One byte lane of the store merge: take the new byte when the lane is hit.
module subword_mem_ctrl_lane #(
  parameter int VEC_W = 8
) (
  input  logic             sel,
  input  logic [VEC_W-1:0] old_b,
  input  logic [VEC_W-1:0] new_b,
  output logic [VEC_W-1:0] out_b
);
  assign out_b = sel ? new_b : old_b;
endmodule

module subword_mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

`ifdef LSU_ALIGN_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, RESP} state_t;
  state_t state;

  // registered request fields
  logic        we_q, sgn_q;
  logic [1:0]  size_q, off_q;
  logic [15:0] wd_q;

  logic accept, acc_mis;
  logic [1:0] acc_off;

  assign req_ready = (state == IDLE) & ~rst;
  assign accept    = req_valid & req_ready;

  assign acc_mis = ((req_size == 2'b01) & req_addr[0]) |
                   (req_size[1] & (req_addr[1:0] != 2'b00));

  // Offset forced to natural alignment; in trap builds misaligned requests
  // never reach memory so the forcing is harmless there.
  always_comb begin
    acc_off = 2'b00;
    case (req_size)
      2'b00:   acc_off = req_addr[1:0];
      2'b01:   acc_off = {req_addr[1], 1'b0};
      default: acc_off = 2'b00;
    endcase
  end

  // Lane view of the fetched word: lane 3 is bits [31:24] (byte offset 0).
  logic [NUM_LANES-1:0][VEC_W-1:0] rd_lanes, new_lanes, mrg_lanes;
  logic [NUM_LANES-1:0]            lane_sel;

  assign rd_lanes = mem_rdata;

  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
      localparam logic [1:0] BOFF = 2'(NUM_LANES - 1 - i);
      localparam logic       HHI  = ((i / 2) == 1);
      localparam logic       ODD  = ((i % 2) == 1);

      // byte: lane at offset; half: upper pair for offset 0, lower for 2
      assign lane_sel[i] = (size_q == 2'b00) ? (off_q == BOFF) :
                           (size_q == 2'b01) ? (HHI == ~off_q[1]) : 1'b1;
      assign new_lanes[i] = ((size_q == 2'b01) && ODD) ? wd_q[15:8] : wd_q[7:0];

      subword_mem_ctrl_lane #(.VEC_W(VEC_W)) u_lane (
        .sel   (lane_sel[i]),
        .old_b (rd_lanes[i]),
        .new_b (new_lanes[i]),
        .out_b (mrg_lanes[i])
      );
    end
  endgenerate

  // Load formatting
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_val;

  always_comb begin
    ld_b   = rd_lanes[~off_q];          // lane index = 3 - offset
    ld_h   = off_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    ld_val = mem_rdata;
    case (size_q)
      2'b00:   ld_val = {{24{sgn_q & ld_b[7]}}, ld_b};
      2'b01:   ld_val = {{16{sgn_q & ld_h[15]}}, ld_h};
      default: ld_val = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      we_q      <= 1'b0;
      sgn_q     <= 1'b0;
      size_q    <= 2'b00;
      off_q     <= 2'b00;
      wd_q      <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          we_q   <= req_we;
          sgn_q  <= req_signed;
          size_q <= req_size;
          off_q  <= acc_off;
          wd_q   <= req_wdata[15:0];
          if (TRAP && acc_mis) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= RESP;
          end else begin
            mem_addr <= req_addr[ADDR_W-1:2];
            mem_req  <= 1'b1;
            if (req_we && req_size[1]) begin
              mem_we    <= 1'b1;
              mem_wdata <= req_wdata;
              state     <= WRITE;
            end else begin
              mem_we <= 1'b0;
              state  <= READ;
            end
          end
        end
        READ: begin
          mem_req <= 1'b0;
          state   <= WAIT;
        end
        WAIT: begin
          if (we_q) begin
            mem_wdata <= mrg_lanes;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            state     <= WRITE;
          end else begin
            rsp_rdata <= ld_val;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        WRITE: begin
          mem_req   <= 1'b0;
          mem_we    <= 1'b0;
          rsp_rdata <= '0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_subword_mem_ctrl.sv
// Directed bench for subword_mem_ctrl with a behavioural word memory.
module tb_subword_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, mem_req, mem_we;
  logic [31:0] rsp_rdata, mem_wdata, mem_rdata;
  logic [29:0] mem_addr;

  int nchk = 0, nerr = 0;

  subword_mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // word memory with a backdoor write port for preloading
  logic [31:0] tbmem [0:255];
  logic        bd_we = 1'b0;
  logic [7:0]  bd_idx = '0;
  logic [31:0] bd_dat = '0;

  always @(posedge clk) begin
    if (bd_we) tbmem[bd_idx] <= bd_dat;
    if (mem_req) begin
      if (mem_we) tbmem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= tbmem[mem_addr[7:0]];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [7:0] idx, input logic [31:0] val);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = idx; bd_dat = val;
    @(posedge clk);
    #1 bd_we = 1'b0;
  endtask

  // Issue one access, then observe 8 cycles; cycle c is sampled at the
  // negedge following edge c-1 (edge 0 = accept edge).
  task automatic access(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int rsp_cyc, output int rd_cyc, output int wr_cyc,
                        output int nrd, output int nwr,
                        output logic [31:0] rdata, output logic [31:0] wdat,
                        output logic err);
    int guard;
    rsp_cyc = -1; rd_cyc = -1; wr_cyc = -1; nrd = 0; nwr = 0;
    rdata = 'x; wdat = 'x; err = 1'bx;
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    chk("ready_before_access", 32'(req_ready), 32'd1);
    req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_req && !mem_we) begin nrd++; if (rd_cyc < 0) rd_cyc = c; end
      if (mem_req && mem_we) begin
        nwr++;
        if (wr_cyc < 0) begin wr_cyc = c; wdat = mem_wdata; end
      end
      if (rsp_valid && rsp_cyc < 0) begin rsp_cyc = c; rdata = rsp_rdata; err = rsp_err; end
    end
  endtask

  int rc, rdc, wrc, nr, nw;
  logic [31:0] rd, wdt;
  logic er;
  logic [7:0] rdy_v, rv_v, rs_v, ws_v;

  // load vectors: size, signed, addr, expected
  logic [1:0]  ld_sz  [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
  logic        ld_sg  [6] = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1};
  logic [31:0] ld_a   [6] = '{32'h101, 32'h101, 32'h100, 32'h102, 32'h100, 32'h103};
  logic [31:0] ld_exp [6] = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF,
                              32'h00007F01, 32'h00000080, 32'h00000001};

  initial begin
    // reset state
    @(negedge clk);
    chk("rst_ready",     32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err",   32'(rsp_err),   32'd0);
    chk("rst_mem_req",   32'(mem_req),   32'd0);
    chk("rst_mem_we",    32'(mem_we),    32'd0);
    chk("rst_rdata",     rsp_rdata,      32'd0);
    chk("rst_mem_addr",  32'(mem_addr),  32'd0);
    chk("rst_mem_wdata", mem_wdata,      32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("ready_after_rst", 32'(req_ready), 32'd1);

    poke(8'h40, 32'h80FF7F01);
    poke(8'h41, 32'h00000000);

    // loads
    for (int k = 0; k < 6; k++) begin
      access(1'b0, ld_sz[k], ld_sg[k], ld_a[k], 32'h0, rc, rdc, wrc, nr, nw, rd, wdt, er);
      chk($sformatf("load%0d_data", k), rd, ld_exp[k]);
      chk($sformatf("load%0d_rsp_cyc", k), 32'(rc), 32'd3);
      chk($sformatf("load%0d_rd_cyc", k), 32'(rdc), 32'd1);
      chk($sformatf("load%0d_nrd", k), 32'(nr), 32'd1);
      chk($sformatf("load%0d_nwr", k), 32'(nw), 32'd0);
    end
    chk("rdata_hold_after_load", rsp_rdata, 32'h00000001);

    // half store @0x102
    access(1'b1, 2'b01, 1'b0, 32'h102, 32'h1234ABCD, rc, rdc, wrc, nr, nw, rd, wdt, er);
    chk("sth_rd_cyc",  32'(rdc), 32'd1);
    chk("sth_wr_cyc",  32'(wrc), 32'd3);
    chk("sth_wdata",   wdt, 32'h80FFABCD);
    chk("sth_rsp_cyc", 32'(rc), 32'd4);
    chk("sth_nwr",     32'(nw), 32'd1);
    chk("sth_rdata",   rd, 32'd0);
    chk("sth_mem",     tbmem[8'h40], 32'h80FFABCD);

    // byte store @0x100 on the original word
    poke(8'h40, 32'h80FF7F01);
    access(1'b1, 2'b00, 1'b0, 32'h100, 32'h00000012, rc, rdc, wrc, nr, nw, rd, wdt, er);
    chk("stb_wdata",   wdt, 32'h12FF7F01);
    chk("stb_rsp_cyc", 32'(rc), 32'd4);
    chk("stb_mem",     tbmem[8'h40], 32'h12FF7F01);

    // word store @0x104
    poke(8'h40, 32'h80FF7F01);
    access(1'b1, 2'b10, 1'b0, 32'h104, 32'hDEADBEEF, rc, rdc, wrc, nr, nw, rd, wdt, er);
    chk("stw_wr_cyc",  32'(wrc), 32'd1);
    chk("stw_nrd",     32'(nr), 32'd0);
    chk("stw_nwr",     32'(nw), 32'd1);
    chk("stw_rsp_cyc", 32'(rc), 32'd2);
    chk("stw_mem",     tbmem[8'h41], 32'hDEADBEEF);
    chk("mem_addr_hold", 32'(mem_addr), 32'h41);
    chk("mem_wdata_hold", mem_wdata, 32'hDEADBEEF);

    // misaligned word load @0x102, then misaligned half @0x103
    access(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, rc, rdc, wrc, nr, nw, rd, wdt, er);
`ifdef LSU_ALIGN_TRAP_EN
    chk("misw_err",     32'(er), 32'd1);
    chk("misw_rsp_cyc", 32'(rc), 32'd1);
    chk("misw_mem",     32'(nr + nw), 32'd0);
    chk("misw_rdata",   rd, 32'd0);
`else
    chk("misw_err",     32'(er), 32'd0);
    chk("misw_rsp_cyc", 32'(rc), 32'd3);
    chk("misw_data",    rd, 32'h80FF7F01);
`endif
    access(1'b0, 2'b01, 1'b0, 32'h103, 32'h0, rc, rdc, wrc, nr, nw, rd, wdt, er);
`ifdef LSU_ALIGN_TRAP_EN
    chk("mish_err",  32'(er), 32'd1);
    chk("mish_mem",  32'(nr + nw), 32'd0);
`else
    chk("mish_err",  32'(er), 32'd0);
    chk("mish_data", rd, 32'h00007F01);
`endif
    // word size 11 load treated as word
    access(1'b0, 2'b11, 1'b1, 32'h100, 32'h0, rc, rdc, wrc, nr, nw, rd, wdt, er);
    chk("ld_sz3_data", rd, 32'h80FF7F01);

    // back-to-back with req_valid held high; req_we glitches while busy
    @(negedge clk);
    req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h100;
    req_valid = 1'b1;
    rdy_v = '0; rv_v = '0; rs_v = '0; ws_v = '0;
    @(posedge clk);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      rdy_v[c-1] = req_ready;
      rv_v[c-1]  = rsp_valid;
      rs_v[c-1]  = mem_req & ~mem_we;
      ws_v[c-1]  = mem_req & mem_we;
      if (c == 1) req_we = 1'b1;
      if (c == 3) req_we = 1'b0;
      if (c == 8) req_valid = 1'b0;
    end
    chk("b2b_ready_pattern", 32'(rdy_v), 32'h88);
    chk("b2b_rsp_pattern",   32'(rv_v),  32'h44);
    chk("b2b_read_pattern",  32'(rs_v),  32'h11);
    chk("b2b_write_pattern", 32'(ws_v),  32'h00);
    chk("b2b_rdata",         rsp_rdata,  32'h80FF7F01);

    // reset during WAIT of a half store
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b01; req_addr = 32'h102; req_wdata = 32'h00005555;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);          // cycle 1: READ
    @(negedge clk);          // cycle 2: WAIT
    rst = 1'b1;
    #1;
    chk("rstw_mem_req",   32'(mem_req),   32'd0);
    chk("rstw_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstw_ready",     32'(req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rstw_ready_after", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("rstw_mem", tbmem[8'h40], 32'h80FF7F01);

    // reset during WRITE of a half store: write strobe drops before its edge
    @(negedge clk);
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);          // cycle 3: WRITE
    chk("rstwr_pre_we", 32'(mem_req & mem_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstwr_mem_req", 32'(mem_req), 32'd0);
    chk("rstwr_mem_we",  32'(mem_we),  32'd0);
    chk("rstwr_wdata",   mem_wdata,    32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rstwr_mem", tbmem[8'h40], 32'h80FF7F01);
    chk("rstwr_ready", 32'(req_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/subword_mem_ctrl.md
# subword_mem_ctrl

- Memory-side load/store sequencer between the MEM stage and a word-wide, single-port synchronous data memory that has no byte enables.
- Loads: one word read, then big-endian lane extract with sign or zero extension.
- Byte and halfword stores: read-modify-write, splicing the new lane into the fetched word.
- Stalls the pipeline through a ready/valid handshake until the access completes.

## Interface
- `ADDR_W`, default 32: byte-address width of `req_addr`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: MEM stage presents an access.
- `req_ready` out 1: block accepts an access; the handshake completes on a rising edge with `req_valid & req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 = byte, 01 = half, 10 = word, 11 = treated as word.
- `req_signed` in 1: sign-extend the load result; ignored for stores and word loads.
- `req_addr` in `ADDR_W`: byte address.
- `req_wdata` in 32: store data, right-justified (byte in [7:0], half in [15:0]).
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 32: load result; 0 for stores and errors.
- `rsp_err` out 1: misaligned access; qualified by `rsp_valid`.
- `mem_req` out 1: memory access strobe.
- `mem_we` out 1: memory write.
- `mem_addr` out `ADDR_W-2`: word address, `req_addr[ADDR_W-1:2]`.
- `mem_wdata` out 32: word written.
- `mem_rdata` in 32: read data, valid exactly one cycle after a read strobe.

## Operation
- Accept stage: the request is registered on the accept edge; all later behaviour uses only registered fields.
- FSM states: IDLE, READ, WAIT, WRITE, RESP.
  - IDLE: `req_ready`=1. On accept, go to RESP if misaligned and `LSU_ALIGN_TRAP_EN` is defined; to WRITE for a word store; to READ otherwise.
  - READ: `mem_req`=1, `mem_we`=0; go to WAIT.
  - WAIT: sample `mem_rdata`.
    - Load: capture the formatted result into `rsp_rdata`; go to RESP.
    - Sub-word store: capture the merged word into `mem_wdata`; go to WRITE.
  - WRITE: `mem_req`=1, `mem_we`=1; go to RESP.
  - RESP: `rsp_valid`=1; go to IDLE.
- Big-endian lanes:
  - Byte offsets 0..3 map to bits [31:24], [23:16], [15:8], [7:0].
  - Half offset 0 maps to [31:16]; half offset 2 maps to [15:0].
- Load extension:
  - `req_signed`=1 replicates the lane MSB.
  - `req_signed`=0 zero-fills.
  - Word loads pass through unchanged.
- Store merge: only the addressed lane is replaced by `req_wdata[7:0]` or `req_wdata[15:0]`; every other bit keeps the fetched value.
- Misaligned means: half with `addr[0]`=1, or word with `addr[1:0]`≠0. Bytes are never misaligned.
- Output hold rules:
  - `rsp_rdata` holds its value until the next load completes.
  - `rsp_rdata` is cleared to 0 when a store or error completes.
  - `mem_addr` and `mem_wdata` hold their values between accesses.
- `mem_req` is asserted only in READ and WRITE; no other state touches memory.
- `req_ready`=0 in every state except IDLE, and 0 while `rst` is high.

## Timing
- Cycle 0 is the accept edge.
- Cycle at which `rsp_valid` is asserted:
  - Load: READ in cycle 1, WAIT in cycle 2, `rsp_valid` in cycle 3.
  - Sub-word store: read in cycle 1, write in cycle 3, `rsp_valid` in cycle 4.
  - Word store: write in cycle 1, `rsp_valid` in cycle 2, no read.
  - Trapped misaligned access: `rsp_valid`+`rsp_err` in cycle 1, no memory access.
- The next accept is possible at the earliest in the cycle after RESP; there is no overlap between accesses.
- `req_valid` may drop or change while the block is busy without effect.
- Reset values:
  - State IDLE.
  - `rsp_valid`, `rsp_err`, `mem_req`, `mem_we` = 0.
  - `rsp_rdata`, `mem_wdata`, `mem_addr` = 0.
- Reset mid-operation: `mem_req` and `mem_we` fall immediately and the in-flight write is abandoned. Memory is unmodified unless a write edge already occurred.

## Configuration
- `LSU_ALIGN_TRAP_EN` defined: misaligned requests complete with `rsp_err`=1, `rsp_rdata`=0, and no memory access.
- `LSU_ALIGN_TRAP_EN` undefined:
  - The low address bits are forced to alignment (half clears `addr[0]`, word clears `addr[1:0]`).
  - The access proceeds normally.
  - `rsp_err` is tied to 0.

## Test plan
- Memory 0x100 = 0x80FF7F01:
  - Signed byte load @0x101 returns 0xFFFFFFFF.
  - Unsigned byte load @0x101 returns 0x000000FF.
  - Signed half load @0x100 returns 0xFFFF80FF.
  - Unsigned half load @0x102 returns 0x00007F01.
  - Each load: `rsp_valid` in cycle 3, exactly one read strobe.
- Half store @0x102, `req_wdata`=0x1234ABCD: read in cycle 1, write of 0x80FFABCD in cycle 3, `rsp_valid` in cycle 4. Byte store @0x100, data 0x12, writes 0x12FF7F01.
- Word store @0x104, data 0xDEADBEEF: single write strobe in cycle 1, no read, `rsp_valid` in cycle 2.
- Word load @0x102:
  - With the macro: `rsp_err`=1 in cycle 1, `mem_req` never asserted.
  - Without the macro: reads word 0x100, returns 0x80FF7F01.
- Back-to-back requests with `req_valid` held high: `req_ready` is low in every state except IDLE; the second access is accepted only after the first access's RESP.
- `rst` asserted during WAIT of a half store: `mem_req` and `rsp_valid` go to 0 immediately, memory is unchanged, and `req_ready`=1 after reset release.
